// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute sequencer: state encoding,
// supported opcodes and the bit layout of the 16-bit instruction word.
package alu_exec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        LD_A,
        OP_B,
        LD_B,
        EXEC,
        DRIVE,
        WB,
        DONE
    } state_t;

    localparam logic [3:0] OPC_IMM_A = 4'b0001;
    localparam logic [3:0] OPC_IMM_B = 4'b0010;
    localparam logic [3:0] OPC_RR_A  = 4'b0011;
    localparam logic [3:0] OPC_RR_B  = 4'b0100;

    localparam int INSTR_W = 16;
    localparam int IDX_W   = 6;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int P1_MSB  = 11;
    localparam int P1_LSB  = 6;
    localparam int P2_MSB  = 5;
    localparam int P2_LSB  = 0;

    function automatic logic is_imm(input logic [3:0] opc);
        return (opc == OPC_IMM_A) || (opc == OPC_IMM_B);
    endfunction

    function automatic logic is_rr(input logic [3:0] opc);
        return (opc == OPC_RR_A) || (opc == OPC_RR_B);
    endfunction

endpackage

// File: rtl/alu_exec_fsm_if.sv
// Handshake and datapath-control bundle between the execute sequencer
// (slave side) and whatever issues instructions to it (master side).
interface alu_exec_fsm_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 6
);
    logic                start;
    logic                abort;
    logic [15:0]         instruction;
    logic [NUM_REGS-1:0] rxOut;
    logic [NUM_REGS-1:0] rxIn;
    logic                ALUin0;
    logic                ALUin1;
    logic                ALUoutlatch;
    logic                ALUoutEN;
    logic                ALUImmOut;
    logic                pcInc;
    logic                done;
    logic                busy;
    logic                err;
    logic [3:0]          alu_op;
    logic [DATA_W-1:0]   immOut;

    modport master (
        output start, abort, instruction,
        input  rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, ALUImmOut,
               pcInc, done, busy, err, alu_op, immOut
    );

    modport slave (
        input  start, abort, instruction,
        output rxOut, rxIn, ALUin0, ALUin1, ALUoutlatch, ALUoutEN, ALUImmOut,
               pcInc, done, busy, err, alu_op, immOut
    );
endinterface

// File: rtl/alu_exec_fsm_onehot_dec.sv
// Register-index decoder: index i lights bit NUM_REGS-1-i; any index at or
// beyond NUM_REGS gives an all-zero enable vector.
module onehot_dec
    import alu_exec_pkg::*;
#(
    parameter int NUM_REGS = 6
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot
);

    // NOTE: every output bit is assigned on every pass, so no latch can form.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[NUM_REGS-1-i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/alu_exec_fsm.sv
// Moore sequencer that walks one ALU instruction through read, operand load,
// execute, drive and write-back. Define IMM_SIGN_EXT_EN to sign-extend the
// 6-bit immediate; by default it is zero-extended.
module alu_exec_fsm
    import alu_exec_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 6
) (
    input logic           clk,
    input logic           rst,
    alu_exec_fsm_if.slave bus
);

    state_t               state, state_n;
    logic [INSTR_W-1:0]   instr, instr_n;
    logic [3:0]           opc_in, opc_n;
    logic [IDX_W-1:0]     p1_n, p2_n, rd_idx;
    logic [NUM_REGS-1:0]  rd_onehot, wr_onehot;
    logic [DATA_W-1:0]    imm_ext;
    logic                 reject, idx_bad;

    logic [NUM_REGS-1:0]  rx_out_n, rx_in_n, rx_out_q, rx_in_q;
    logic                 alu_in0_n, alu_in1_n, latch_n, out_en_n, imm_en_n;
    logic                 pc_inc_n, done_n, busy_n, err_n;
    logic                 alu_in0_q, alu_in1_q, latch_q, out_en_q, imm_en_q;
    logic                 pc_inc_q, done_q, busy_q, err_q;
    logic [3:0]           alu_op_n, alu_op_q;
    logic [DATA_W-1:0]    imm_out_n, imm_out_q;

    assign opc_in = bus.instruction[OPC_MSB:OPC_LSB];
    assign reject = (state == IDLE) && bus.start && !bus.abort
                    && !(is_imm(opc_in) || is_rr(opc_in));

    // Abort outranks everything, including a start seen in IDLE.
    always_comb begin
        state_n = state;
        instr_n = instr;
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start && (is_imm(opc_in) || is_rr(opc_in))) begin
                    state_n = RD_A;
                    instr_n = bus.instruction;
                end
                RD_A:    state_n = LD_A;
                LD_A:    state_n = OP_B;
                OP_B:    state_n = LD_B;
                LD_B:    state_n = EXEC;
                EXEC:    state_n = DRIVE;
                DRIVE:   state_n = WB;
                WB:      state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign opc_n  = instr_n[OPC_MSB:OPC_LSB];
    assign p1_n   = instr_n[P1_MSB:P1_LSB];
    assign p2_n   = instr_n[P2_MSB:P2_LSB];
    assign rd_idx = ((state_n == OP_B) || (state_n == LD_B)) ? p2_n : p1_n;
    assign idx_bad = (int'(p1_n) >= NUM_REGS)
                     || (is_rr(opc_n) && (int'(p2_n) >= NUM_REGS));

`ifdef IMM_SIGN_EXT_EN
    assign imm_ext = {{(DATA_W-IDX_W){p2_n[IDX_W-1]}}, p2_n};
`else
    assign imm_ext = {{(DATA_W-IDX_W){1'b0}}, p2_n};
`endif

    onehot_dec #(.NUM_REGS(NUM_REGS)) u_rd_dec (.idx(rd_idx), .onehot(rd_onehot));
    onehot_dec #(.NUM_REGS(NUM_REGS)) u_wr_dec (.idx(p1_n),   .onehot(wr_onehot));

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        rx_out_n  = '0;
        rx_in_n   = '0;
        alu_in0_n = 1'b0;
        alu_in1_n = 1'b0;
        latch_n   = 1'b0;
        out_en_n  = 1'b0;
        imm_en_n  = 1'b0;
        imm_out_n = '0;
        pc_inc_n  = 1'b0;
        done_n    = 1'b0;
        err_n     = reject;
        case (state_n)
            RD_A: begin
                rx_out_n = rd_onehot;
                pc_inc_n = 1'b1;
            end
            LD_A: begin
                rx_out_n  = rd_onehot;
                alu_in0_n = 1'b1;
            end
            OP_B, LD_B: begin
                alu_in1_n = (state_n == LD_B);
                if (is_imm(opc_n)) begin
                    imm_en_n  = 1'b1;
                    imm_out_n = imm_ext;
                end else begin
                    rx_out_n = rd_onehot;
                end
            end
            EXEC:  latch_n  = 1'b1;
            DRIVE: out_en_n = 1'b1;
            WB: begin
                out_en_n = 1'b1;
                rx_in_n  = wr_onehot;
            end
            DONE: begin
                done_n = 1'b1;
                err_n  = idx_bad;
            end
            default: ;
        endcase
        busy_n   = (state_n != IDLE);
        alu_op_n = busy_n ? opc_n : 4'd0;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            instr     <= '0;
            rx_out_q  <= '0;
            rx_in_q   <= '0;
            alu_in0_q <= 1'b0;
            alu_in1_q <= 1'b0;
            latch_q   <= 1'b0;
            out_en_q  <= 1'b0;
            imm_en_q  <= 1'b0;
            imm_out_q <= '0;
            pc_inc_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            alu_op_q  <= '0;
        end else begin
            state     <= state_n;
            instr     <= instr_n;
            rx_out_q  <= rx_out_n;
            rx_in_q   <= rx_in_n;
            alu_in0_q <= alu_in0_n;
            alu_in1_q <= alu_in1_n;
            latch_q   <= latch_n;
            out_en_q  <= out_en_n;
            imm_en_q  <= imm_en_n;
            imm_out_q <= imm_out_n;
            pc_inc_q  <= pc_inc_n;
            done_q    <= done_n;
            busy_q    <= busy_n;
            err_q     <= err_n;
            alu_op_q  <= alu_op_n;
        end
    end

    assign bus.rxOut       = rx_out_q;
    assign bus.rxIn        = rx_in_q;
    assign bus.ALUin0      = alu_in0_q;
    assign bus.ALUin1      = alu_in1_q;
    assign bus.ALUoutlatch = latch_q;
    assign bus.ALUoutEN    = out_en_q;
    assign bus.ALUImmOut   = imm_en_q;
    assign bus.immOut      = imm_out_q;
    assign bus.pcInc       = pc_inc_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.alu_op      = alu_op_q;

endmodule

// File: doc/alu_exec_fsm.md
ALU_EXEC_FSM -- requirements
Module: alu_exec_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ALU/bus data width (>=8).
REQ-002 SHALL have parameter NUM_REGS, default 6, general registers addressed (1..64).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: start in 1 (begin execute); abort in 1 (fetch active, cancel); instruction in 16 (opcode[15:12], param1[11:6], param2[5:0]).
REQ-006 SHALL have ports: rxOut out NUM_REGS (one-hot read enable); rxIn out NUM_REGS (one-hot write enable); register index i maps to bit NUM_REGS-1-i.
REQ-007 SHALL have ports: ALUin0, ALUin1, ALUoutlatch, ALUoutEN, ALUImmOut, pcInc, done, busy, err, each out 1; alu_op out 4; immOut out DATA_W.

Function
REQ-008 SHALL be a Moore FSM: IDLE, RD_A, LD_A, OP_B, LD_B, EXEC, DRIVE, WB, DONE; outputs decode from registered state and captured fields only.
REQ-009 SHALL capture instruction into an internal register on the edge leaving IDLE; later instruction changes SHALL be ignored.
REQ-010 SHALL classify opcodes 4'b0001/4'b0010 as immediate, 4'b0011/4'b0100 as register-register; alu_op = captured opcode while busy, else 0.
REQ-011 IDLE with start=1 and supported opcode SHALL go to RD_A; unsupported opcode SHALL stay IDLE and pulse err one cycle.
REQ-012 SHALL advance RD_A->LD_A->OP_B->LD_B->EXEC->DRIVE->WB->DONE->IDLE, one state per cycle; done high exactly 8 cycles after the accepting start edge.
REQ-013 RD_A: rxOut=onehot(param1), pcInc=1. LD_A: rxOut=onehot(param1), ALUin0=1.
REQ-014 OP_B/LD_B immediate: ALUImmOut=1, immOut=extended param2; register: rxOut=onehot(param2). LD_B additionally ALUin1=1.
REQ-015 EXEC: ALUoutlatch=1. DRIVE: ALUoutEN=1. WB: ALUoutEN=1, rxIn=onehot(param1). DONE: done=1.
REQ-016 Any register index >= NUM_REGS SHALL yield all-zero enables for that operand; err SHALL be high in DONE; sequence length unchanged.
REQ-017 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-018 abort=1 SHALL force IDLE on the next edge from any state (abort wins over start); no done, no rxIn in that cycle onward.
REQ-019 immOut SHALL be 0 outside OP_B/LD_B; at most one bit of rxOut and of rxIn SHALL be high in any cycle.

Reset
REQ-020 rst=1 SHALL immediately force IDLE and all outputs 0, captured instruction 0, including mid-sequence.
REQ-021 First accepting start edge after rst deassertion SHALL behave as REQ-011.

Configuration
REQ-022 With IMM_SIGN_EXT_EN defined, immOut SHALL be param2 sign-extended from bit 5 to DATA_W.
REQ-023 Without IMM_SIGN_EXT_EN, immOut SHALL be param2 zero-extended to DATA_W.

Structure
REQ-024 Package alu_exec_pkg SHALL hold state enum, opcode constants, field bit positions.
REQ-025 Sub-module onehot_dec (index -> NUM_REGS one-hot, zero when out of range) SHALL be instantiated for rxOut and rxIn.

Verification
REQ-026 Immediate: opcode 0001, param1=2, param2=5, start 1 cycle -> rxOut=001000 in RD_A/LD_A, immOut=5 in OP_B/LD_B, rxIn=001000 in WB, done on cycle 8, pcInc exactly once.
REQ-027 Reg-reg: opcode 0011, param1=0, param2=5 -> rxOut=100000 RD_A/LD_A, 000001 OP_B/LD_B, ALUImmOut=0 throughout, rxIn=100000 in WB.
REQ-028 Sign extension: param2=6'b111110, DATA_W=16 -> immOut=16'hFFFE with IMM_SIGN_EXT_EN, 16'h003E without.
REQ-029 Abort/reset: abort=1 in EXEC -> IDLE next cycle, no done, rxIn never set; rst pulse in DRIVE -> all outputs 0 same cycle.
REQ-030 Errors: opcode 1111 + start -> err one cycle, busy stays 0; param1=7 with NUM_REGS=6 -> rxOut/rxIn all zero, err=1 in DONE.
